// File: rtl/romulus_pkg.sv
// rtl/romulus_pkg.sv - shared types and constants for the Romulus output unit
package romulus_pkg;

    localparam int DOW        = 32;
    localparam int BLK_BYTES  = 16;
    localparam int CNT_W      = 5;
    localparam int WORD_BYTES = DOW / 8;

    typedef enum logic [1:0] {
        OU_IDLE,
        OU_SEND,
        OU_CHECK,
        OU_STATUS
    } ou_state_e;

    function automatic logic [CNT_W-1:0] clamp_bytes(input logic [CNT_W-1:0] nbytes);
        return (nbytes > CNT_W'(BLK_BYTES)) ? CNT_W'(BLK_BYTES) : nbytes;
    endfunction

    // MSB-aligned byte enables for the word at the head of the buffer
    function automatic logic [3:0] keep_from_rem(input logic [CNT_W-1:0] rem);
        case (rem)
            5'd0:    return 4'b0000;
            5'd1:    return 4'b1000;
            5'd2:    return 4'b1100;
            5'd3:    return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/romulus_tag_cmp.sv
// rtl/romulus_tag_cmp.sv - registered constant-time 128-bit tag comparator
module romulus_tag_cmp #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         fail
);

    // Full-width reduction every time: no data-dependent early exit
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            fail <= 1'b0;
        end else if (en) begin
            fail <= |(a ^ b);
        end
    end

endmodule

// File: rtl/romulus_output_unit.sv
// rtl/romulus_output_unit.sv - serialises 128-bit result blocks onto the 32-bit do bus
module romulus_output_unit #(
    parameter int BUSW = 128,
    parameter int DOW  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BUSW-1:0] blk_data,
    input  logic [4:0]      blk_bytes,
    input  logic            blk_last,
    input  logic            blk_tag,
    input  logic            blk_verify,
    input  logic            blk_valid,
    output logic            blk_ready,
    input  logic [BUSW-1:0] tag_ref,
    output logic [DOW-1:0]  do_data,
    output logic [3:0]      do_keep,
    output logic            do_last,
    output logic            do_valid,
    input  logic            do_ready,
    output logic            status_valid,
    input  logic            status_ready,
    output logic            status_fail
);
    import romulus_pkg::*;

    ou_state_e       state_q, state_d;
    logic [BUSW-1:0] shift_q;
    logic [4:0]      rem_q;
    logic            last_q;
    logic            fail_q;

    logic            blk_fire, word_fire, verify_blk;
    logic [4:0]      blk_rem, rem_after;
    logic [3:0]      head_keep;
    logic [DOW-1:0]  byte_mask;

    assign blk_ready  = (state_q == OU_IDLE) & ~rst;
    assign blk_fire   = blk_valid & blk_ready;
    assign word_fire  = do_valid & do_ready;
    assign verify_blk = blk_tag & blk_verify;
    assign blk_rem    = clamp_bytes(blk_bytes);
    assign rem_after  = (rem_q >= 5'd4) ? rem_q - 5'd4 : 5'd0;
    assign head_keep  = keep_from_rem(rem_q);
    assign byte_mask  = {{8{head_keep[3]}}, {8{head_keep[2]}}, {8{head_keep[1]}}, {8{head_keep[0]}}};
    assign status_fail = fail_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        do_valid     = 1'b0;
        do_data      = '0;
        do_keep      = 4'b0000;
        do_last      = 1'b0;
        status_valid = 1'b0;
        case (state_q)
            OU_IDLE: begin
                if (blk_fire) begin
                    if (verify_blk) begin
                        state_d = OU_CHECK;
                    end else if (blk_rem == 5'd0) begin
                        state_d = blk_last ? OU_STATUS : OU_IDLE;
                    end else begin
                        state_d = OU_SEND;
                    end
                end
            end
            OU_SEND: begin
                do_valid = 1'b1;
                do_data  = shift_q[BUSW-1 -: DOW] & byte_mask;
                do_keep  = head_keep;
                do_last  = last_q & (rem_q <= 5'd4);
                if (do_ready && rem_after == 5'd0) begin
                    state_d = last_q ? OU_STATUS : OU_IDLE;
                end
            end
            OU_CHECK: begin
                state_d = OU_STATUS;
            end
            OU_STATUS: begin
                status_valid = 1'b1;
                if (status_ready) begin
                    state_d = OU_IDLE;
                end
            end
            default: begin
                state_d = OU_IDLE;
            end
        endcase
    end

    // The head word is always shift_q's top DOW bits; rem_q tracks bytes left
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            rem_q   <= 5'd0;
            last_q  <= 1'b0;
        end else if (blk_fire) begin
            shift_q <= blk_data;
            rem_q   <= blk_rem;
            last_q  <= blk_last;
        end else if (word_fire) begin
            shift_q <= shift_q << DOW;
            rem_q   <= rem_after;
        end
    end

    romulus_tag_cmp #(
        .W(BUSW)
    ) u_tag_cmp (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == OU_CHECK),
        .clr  (blk_fire & ~verify_blk),
        .a    (shift_q),
        .b    (tag_ref),
        .fail (fail_q)
    );

endmodule

// File: doc/romulus_output_unit.md
# romulus_output_unit

Output-side counterpart of the Romulus datapath's `pdi`/`sdi` input path. It accepts 128-bit result blocks from the datapath `pdo` port and serialises them, MSB-first, onto the 32-bit LWC `do` bus with valid/ready handshake and partial-block byte masking. It verifies the received tag on decryption with a registered constant-time compare, and closes every message with a status beat. It sits between `romulus_datapath.pdo` and the top-level `do_*`/status ports; the controller drives its block interface.

## Interface
Parameters:
- `BUSW`, 128, datapath block width in bits; fixed, other values unsupported.
- `DOW`, 32, output bus width in bits; `BUSW` must be a multiple of `DOW`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `blk_data` in 128: block from the datapath `pdo`; byte 0 is bits 127:120.
- `blk_bytes` in 5: valid bytes in the block, 0..16; values above 16 are treated as 16.
- `blk_last` in 1: last block of the message.
- `blk_tag` in 1: block is a tag.
- `blk_verify` in 1: decrypt mode; a tag block is compared, not output.
- `blk_valid` in 1: block offered.
- `blk_ready` out 1: block accepted when `blk_valid & blk_ready`.
- `tag_ref` in 128: received tag; must be stable from the tag block handshake until the status beat.
- `do_data` out 32: output word.
- `do_keep` out 4: byte enables, MSB-aligned (bit 3 = `do_data[31:24]`).
- `do_last` out 1: final word of the message.
- `do_valid` out 1, `do_ready` in 1: word handshake.
- `status_valid` out 1, `status_ready` in 1: status handshake.
- `status_fail` out 1: 1 = tag mismatch; 0 otherwise.

## Operation
- FSM states: IDLE, SEND, CHECK, STATUS.
- IDLE: `blk_ready=1`. On handshake, capture `blk_data` into the 128-bit shift buffer `buf`, and `min(blk_bytes,16)` into `rem`. Also capture `blk_last`. Then branch:
  - `blk_tag & blk_verify`: go to CHECK.
  - `rem==0`: go to STATUS if `blk_last`, else back to IDLE. The zero-byte block emits no words.
  - Otherwise: go to SEND.
- SEND: `do_valid=1`, `do_data=buf[127:96]`.
  - `do_keep=4'b1111` if `rem>=4`; otherwise the top `rem` bits are set (1→1000, 2→1100, 3→1110).
  - Unused low bytes of `do_data` are driven 0.
  - `do_last = last_q & (rem<=4)`.
- SEND handshake: `buf <= buf<<32` and `rem <= rem - min(rem,4)`. When the new `rem` is 0, go to STATUS if `last_q`, else go to IDLE.
- Encryption tag (`blk_tag & ~blk_verify`): handled as a data block. The controller sets `blk_last=1`.
- CHECK: one cycle. Register `fail_q <= |(buf ^ tag_ref)` (full 128-bit XOR/OR reduction, no early exit), then go to STATUS.
- STATUS: `status_valid=1`. `status_fail = fail_q`, where `fail_q` is cleared on every IDLE block accept that is not a verify tag. On `status_ready` handshake, go to IDLE.
- `do_data`/`do_keep`/`do_last` hold stable while `do_valid & ~do_ready`.
- `rst` at any point: FSM→IDLE, `buf`/`rem`/`fail_q` cleared, and partial words are discarded.

## Timing
- Reset values of all outputs: `blk_ready=0` while `rst` is high, then 1 from the first cycle after. `do_valid=0`, `do_data=0`, `do_keep=0`, `do_last=0`, `status_valid=0`, `status_fail=0`.
- `blk_ready` is registered-state decoded (`state==IDLE & ~rst`), with no combinational path from `blk_valid`.
- Block accepted at cycle t: first word `do_valid` at t+1. With `do_ready` held high, a full block occupies t+1..t+4. The next `blk_ready` is at t+5, giving a sustained rate of 5 cycles per 16 bytes.
- Verify tag accepted at t: CHECK at t+1, `status_valid` at t+2.
- Last word handshake at t: `status_valid` at t+1.
- `do_ready` low stalls indefinitely, with no data loss. `status_ready` low holds STATUS.

## Structure
- `romulus_pkg`: FSM state enum (`OU_IDLE`, `OU_SEND`, `OU_CHECK`, `OU_STATUS`), `DOW`, `BLK_BYTES=16`, byte-count width 5.
- Sub-module `romulus_tag_cmp`: registered constant-time 128-bit comparator with an enable and a clear. The FSM, serialiser and keep decode stay in the top module.

## Test plan
- Full block: encrypt, `blk_data=128'h00112233_44556677_8899AABB_CCDDEEFF`, `bytes=16`, `last=1`, `do_ready=1` → words `00112233`, `44556677`, `8899AABB`, `CCDDEEFF`, all `keep=1111`. `last` is set only on the 4th word; status `fail=0` one cycle later.
- Partial: `bytes=5`, `last=1` → word 1 keep 1111; word 2 `=0x44000000`, keep 1000, `last=1`.
- Backpressure: `do_ready` toggles 1,0,0,1,... → identical word sequence, each word held stable while stalled, no duplicates or drops.
- Tag verify: `blk_tag=1`, `verify=1`.
  - `tag_ref == blk_data` → no `do_valid`, `status_valid` at t+2 with `fail=0`.
  - Flipping bit 0 of `tag_ref` → `fail=1`.
- Empty message: `bytes=0`, `last=1` → no words, `status_valid` at t+1. A following normal block starts with `fail=0`.
- Reset mid-SEND after 2 words → outputs return to reset values and `blk_ready=1` next cycle. A new block then serialises from its byte 0.
